// File: rtl/fp_div_issue_pkg.sv
// Shared types and constants for the FP divider issue front-end.
package fp_div_issue_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [31:0] QNAN = 32'h7FC00000;

  // Cycles from a request seen in IDLE to its response strobe
  localparam int DIV_NOMINAL_LAT = 7;

endpackage

// File: rtl/fp_div_rr_arb2.sv
// Two-way round-robin arbiter; the pointer favours the core that lost the last grant.
module fp_div_rr_arb2 (
  input  logic       in_Clk,
  input  logic       in_Rst_N,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = ptr ? 2'b10 : 2'b01;
    end
  end

  // Granting core 0 hands priority to core 1, and vice versa
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      ptr <= 1'b0;
    end else if (advance && (req != 2'b00)) begin
      ptr <= grant[0];
    end
  end

endmodule

// File: rtl/fp_div_issue.sv
// Two-core issue front-end for the shared FP divider (start/stall initiator).
// Optional BUSY timeout with forced QNaN/error response: define FP_DIV_ISSUE_TIMEOUT_EN.
module fp_div_issue
  import fp_div_issue_pkg::*;
#(
  parameter int TAG_W   = 5,
  parameter int TIMEOUT = 15
) (
  input  logic             in_Clk,
  input  logic             in_Rst_N,
  input  logic             in_req0,
  input  logic [31:0]      in_numA0,
  input  logic [31:0]      in_numB0,
  input  logic [TAG_W-1:0] in_tag0,
  input  logic             in_req1,
  input  logic [31:0]      in_numA1,
  input  logic [31:0]      in_numB1,
  input  logic [TAG_W-1:0] in_tag1,
  output logic             out_busy0,
  output logic             out_busy1,
  output logic             out_valid0,
  output logic             out_valid1,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err,
  output logic             out_div_start,
  output logic [31:0]      out_div_numA,
  output logic [31:0]      out_div_numB,
  input  logic             in_div_stall,
  input  logic [31:0]      in_div_result
);

  state_t           state;
  state_t           next_state;
  logic [1:0]       req;
  logic [1:0]       grant;
  logic             take;
  logic             owner;
  logic             seen_stall;
  logic             done;
  logic             timeout;
  logic [TAG_W-1:0] tag_q;

  assign req  = {in_req1, in_req0};
  assign take = (state == IDLE) && !in_div_stall && (req != 2'b00);
  // Completion needs a stall rise first, so a divider that has not started yet is never mistaken for done
  assign done = (state == BUSY) && seen_stall && !in_div_stall;

  fp_div_rr_arb2 u_arb (
    .in_Clk   (in_Clk),
    .in_Rst_N (in_Rst_N),
    .req      (req),
    .advance  (take),
    .grant    (grant)
  );

`ifdef FP_DIV_ISSUE_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] busy_cnt;
  logic             err_q;

  assign timeout = (state == BUSY) && !done && (busy_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      busy_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) begin
        busy_cnt <= '0;
      end else if (state == BUSY) begin
        busy_cnt <= busy_cnt + CNT_W'(1);
      end
      if (done) begin
        err_q <= 1'b0;
      end else if (timeout) begin
        err_q <= 1'b1;
      end
    end
  end

  assign out_err = (state == RESP) && err_q;
`else
  assign timeout = 1'b0;
  assign out_err = 1'b0;
`endif

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (take) next_state = ISSUE;
      ISSUE:   next_state = BUSY;
      BUSY:    if (done || timeout) next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    out_div_start = 1'b0;
    out_valid0    = 1'b0;
    out_valid1    = 1'b0;
    case (state)
      ISSUE: out_div_start = 1'b1;
      RESP: begin
        out_valid0 = !owner;
        out_valid1 = owner;
      end
      default: ;
    endcase
  end

  assign out_busy0 = in_req0 & ~out_valid0;
  assign out_busy1 = in_req1 & ~out_valid1;
  assign out_tag   = tag_q;

  // Operands stay frozen from the grant until the next grant, covering the whole divide
  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      owner        <= 1'b0;
      tag_q        <= '0;
      out_div_numA <= '0;
      out_div_numB <= '0;
    end else if (take) begin
      owner        <= grant[1];
      tag_q        <= grant[0] ? in_tag0  : in_tag1;
      out_div_numA <= grant[0] ? in_numA0 : in_numA1;
      out_div_numB <= grant[0] ? in_numB0 : in_numB1;
    end
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      seen_stall <= 1'b0;
      out_result <= '0;
    end else begin
      if (state == ISSUE) begin
        seen_stall <= 1'b0;
      end else if ((state == BUSY) && in_div_stall) begin
        seen_stall <= 1'b1;
      end
      if (done) begin
        out_result <= in_div_result;
      end else if (timeout) begin
        out_result <= QNAN;
      end
    end
  end

endmodule

// File: tb/tb_fp_div_issue.sv
// Self-checking bench for fp_div_issue with a behavioural divider and round-robin model.
module tb_fp_div_issue;
  import fp_div_issue_pkg::*;

  localparam int TAG_W   = 5;
  localparam int TIMEOUT = 15;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             req0 = 1'b0, req1 = 1'b0;
  logic [31:0]      numA0 = '0, numB0 = '0, numA1 = '0, numB1 = '0;
  logic [TAG_W-1:0] tag0 = '0, tag1 = '0;
  logic             busy0, busy1, valid0, valid1, err, div_start, div_stall;
  logic [31:0]      result, div_numA, div_numB, div_result;
  logic [TAG_W-1:0] tag_out;

  int errors = 0;
  int checks = 0;
  int ptr_model = 0;
  int stall_cnt = 0;
  logic long_stall = 1'b0;
  logic monitor_en = 1'b0;

  fp_div_issue #(.TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
    .in_Clk        (clk),
    .in_Rst_N      (rst_n),
    .in_req0       (req0),
    .in_numA0      (numA0),
    .in_numB0      (numB0),
    .in_tag0       (tag0),
    .in_req1       (req1),
    .in_numA1      (numA1),
    .in_numB1      (numB1),
    .in_tag1       (tag1),
    .out_busy0     (busy0),
    .out_busy1     (busy1),
    .out_valid0    (valid0),
    .out_valid1    (valid1),
    .out_result    (result),
    .out_tag       (tag_out),
    .out_err       (err),
    .out_div_start (div_start),
    .out_div_numA  (div_numA),
    .out_div_numB  (div_numB),
    .in_div_stall  (div_stall),
    .in_div_result (div_result)
  );

  always #5 clk = ~clk;

  // Single-precision value -> real, valid for normal numbers only
  function automatic real sp_to_real(input logic [31:0] f);
    logic [10:0] e;
    e = 11'(f[30:23]) + 11'd896;
    return $bitstoreal({f[31], e, f[22:0], 29'b0});
  endfunction

  // Reference quotient: IEEE special cases plus real division for normal operands
  function automatic logic [31:0] fdiv_model(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] d;
    logic [10:0] e;
    if (b[30:0] == 31'd0) begin
      if (a[30:0] == 31'd0) return 32'h7FC00000;
      return {a[31] ^ b[31], 31'h7F800000};
    end
    if (a[30:0] == 31'd0) return {a[31] ^ b[31], 31'h0};
    d = $realtobits(sp_to_real(a) / sp_to_real(b));
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] rand_fp();
    return {1'($urandom), 8'($urandom_range(154, 100)), 23'($urandom)};
  endfunction

  // Divider model: stall high for four cycles after each start (or much longer on demand)
  always @(posedge clk) begin
    if (div_start) stall_cnt <= long_stall ? 100 : 4;
    else if (stall_cnt > 0) stall_cnt <= stall_cnt - 1;
  end
  assign div_stall  = (stall_cnt != 0);
  assign div_result = fdiv_model(div_numA, div_numB);

  always @(negedge clk) begin
    if (monitor_en && div_start) begin
      checks++;
      if (div_stall) begin
        errors++;
        $display("[TB] FAIL start_during_stall: start=%b stall=%b required stall=0", div_start, div_stall);
      end
    end
  end

  function automatic logic valid_of(input int c);
    return (c != 0) ? valid1 : valid0;
  endfunction

  function automatic logic busy_of(input int c);
    return (c != 0) ? busy1 : busy0;
  endfunction

  task automatic set_core(input int c, input logic r, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t);
    if (c != 0) begin
      req1 = r; numA1 = a; numB1 = b; tag1 = t;
    end else begin
      req0 = r; numA0 = a; numB0 = b; tag0 = t;
    end
  endtask

  task automatic release_core(input int c);
    @(negedge clk);
    if (c != 0) req1 = 1'b0;
    else req0 = 1'b0;
  endtask

  // Lone request from one core; returns at the negedge where the response was seen
  task automatic run_lone(input int core, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] t, input logic [31:0] exp_res,
                          input logic exp_err, input int exp_lat, input string name);
    int lat;
    logic busy_bad;
    logic other_bad;
    lat = 0;
    busy_bad = 1'b0;
    other_bad = 1'b0;
    set_core(core, 1'b1, a, b, t);
    #1;
    if (!busy_of(core)) busy_bad = 1'b1;
    for (int k = 1; k <= exp_lat + 10; k++) begin
      @(negedge clk);
      if (valid_of(1 - core)) other_bad = 1'b1;
      if (valid_of(core)) begin
        lat = k;
        break;
      end
      if (!busy_of(core)) busy_bad = 1'b1;
    end
    checks++;
    if (lat == 0) begin
      errors++;
      $display("[TB] FAIL %s_no_response: no out_valid%0d within %0d cycles", name, core, exp_lat + 10);
      return;
    end
    ptr_model = 1 - core;
    if (lat != exp_lat) begin
      errors++;
      $display("[TB] FAIL %s_latency: got %0d required %0d", name, lat, exp_lat);
    end
    checks++;
    if (result !== exp_res) begin
      errors++;
      $display("[TB] FAIL %s_result: got %h required %h", name, result, exp_res);
    end
    checks++;
    if (tag_out !== t) begin
      errors++;
      $display("[TB] FAIL %s_tag: got %0d required %0d", name, tag_out, t);
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s_err: got %b required %b", name, err, exp_err);
    end
    checks++;
    if (busy_bad || other_bad || busy_of(core) !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s_busy: busy_gap=%b wrong_valid=%b busy_at_valid=%b required 0/0/0",
               name, busy_bad, other_bad, busy_of(core));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid0, valid1, div_start, err, busy0, busy1} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL reset_ctrl: got %b required 000000", {valid0, valid1, div_start, err, busy0, busy1});
    end
    checks++;
    if ({result, tag_out, div_numA, div_numB} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_data: result=%h tag=%0d numA=%h numB=%h required all 0",
               result, tag_out, div_numA, div_numB);
    end
    rst_n = 1'b1;
    ptr_model = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({valid0, valid1, div_start} !== 3'b0) begin
      errors++;
      $display("[TB] FAIL idle_no_req: got %b required 000", {valid0, valid1, div_start});
    end
    monitor_en = 1'b1;
  endtask

  task automatic test_simultaneous;
    int w, l, kw, kl;
    logic [31:0] exp_res [2];
    logic [TAG_W-1:0] tg [2];
    logic [31:0] res_w;
    logic [TAG_W-1:0] tag_w;
    logic busy_bad;
    exp_res[0] = 32'h40400000;
    exp_res[1] = 32'h3E800000;
    tg[0] = 5'd7;
    tg[1] = 5'd21;
    w = ptr_model;
    l = 1 - w;
    kw = 0;
    kl = 0;
    busy_bad = 1'b0;
    res_w = '0;
    tag_w = '0;
    set_core(0, 1'b1, 32'h40C00000, 32'h40000000, tg[0]);
    set_core(1, 1'b1, 32'h3F800000, 32'h40800000, tg[1]);
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (valid_of(l)) begin
        kl = k;
        break;
      end
      if (!busy_of(l)) busy_bad = 1'b1;
      if (kw == 0 && valid_of(w)) begin
        kw = k;
        res_w = result;
        tag_w = tag_out;
      end else if (kw != 0 && k == kw + 1) begin
        set_core(w, 1'b0, '0, '0, '0);
      end
    end
    checks++;
    if (kw != DIV_NOMINAL_LAT || res_w !== exp_res[w] || tag_w !== tg[w]) begin
      errors++;
      $display("[TB] FAIL sim_winner%0d: lat=%0d res=%h tag=%0d required lat=%0d res=%h tag=%0d",
               w, kw, res_w, tag_w, DIV_NOMINAL_LAT, exp_res[w], tg[w]);
    end
    checks++;
    if (kl != DIV_NOMINAL_LAT + 8 || result !== exp_res[l] || tag_out !== tg[l]) begin
      errors++;
      $display("[TB] FAIL sim_loser%0d: lat=%0d res=%h tag=%0d required lat=%0d res=%h tag=%0d",
               l, kl, result, tag_out, DIV_NOMINAL_LAT + 8, exp_res[l], tg[l]);
    end
    checks++;
    if (busy_bad) begin
      errors++;
      $display("[TB] FAIL sim_loser_busy: got busy drop before response, required held high");
    end
    ptr_model = w;
    release_core(l);
  endtask

  task automatic test_lone_and_special;
    run_lone(0, 32'h3F800000, 32'h40000000, 5'd3, 32'h3F000000, 1'b0, DIV_NOMINAL_LAT, "half");
    release_core(0);
    run_lone(1, 32'h3F800000, 32'h00000000, 5'd9, 32'h7F800000, 1'b0, DIV_NOMINAL_LAT, "div_by_zero");
    release_core(1);
    run_lone(0, 32'h00000000, 32'h00000000, 5'd30, 32'h7FC00000, 1'b0, DIV_NOMINAL_LAT, "zero_by_zero");
    release_core(0);
  endtask

  task automatic test_random_lone;
    logic [31:0] a, b;
    int c;
    for (int i = 0; i < 4; i++) begin
      a = rand_fp();
      b = rand_fp();
      c = int'($urandom_range(1, 0));
      run_lone(c, a, b, TAG_W'($urandom), fdiv_model(a, b), 1'b0, DIV_NOMINAL_LAT, "random");
      release_core(c);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a [2];
    logic [31:0] b [2];
    logic [TAG_W-1:0] tg [2];
    int exp_owner, got, last_k, o;
    for (int c = 0; c < 2; c++) begin
      a[c] = rand_fp();
      b[c] = rand_fp();
      tg[c] = TAG_W'($urandom);
      set_core(c, 1'b1, a[c], b[c], tg[c]);
    end
    exp_owner = ptr_model;
    got = 0;
    last_k = 0;
    for (int k = 1; k <= 80 && got < 4; k++) begin
      @(negedge clk);
      if (valid0 || valid1) begin
        o = valid1 ? 1 : 0;
        checks++;
        if (o != exp_owner || (valid0 && valid1)) begin
          errors++;
          $display("[TB] FAIL b2b_owner: got valid0=%b valid1=%b required core %0d", valid0, valid1, exp_owner);
        end
        checks++;
        if (result !== fdiv_model(a[exp_owner], b[exp_owner]) || tag_out !== tg[exp_owner]) begin
          errors++;
          $display("[TB] FAIL b2b_data: got %h/%0d required %h/%0d", result, tag_out,
                   fdiv_model(a[exp_owner], b[exp_owner]), tg[exp_owner]);
        end
        checks++;
        if (k - last_k != ((got == 0) ? DIV_NOMINAL_LAT : 8)) begin
          errors++;
          $display("[TB] FAIL b2b_spacing: got %0d cycles required %0d", k - last_k,
                   (got == 0) ? DIV_NOMINAL_LAT : 8);
        end
        last_k = k;
        got++;
        ptr_model = 1 - exp_owner;
        a[exp_owner] = rand_fp();
        b[exp_owner] = rand_fp();
        tg[exp_owner] = TAG_W'($urandom);
        set_core(exp_owner, 1'b1, a[exp_owner], b[exp_owner], tg[exp_owner]);
        exp_owner = ptr_model;
      end
    end
    checks++;
    if (got != 4) begin
      errors++;
      $display("[TB] FAIL b2b_count: got %0d responses required 4", got);
    end
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

`ifdef FP_DIV_ISSUE_TIMEOUT_EN
  task automatic test_timeout;
    logic [31:0] a, b;
    logic early_start;
    early_start = 1'b0;
    long_stall = 1'b1;
    run_lone(0, rand_fp(), rand_fp(), 5'd11, QNAN, 1'b1, TIMEOUT + 2, "timeout");
    long_stall = 1'b0;
    a = rand_fp();
    b = rand_fp();
    set_core(0, 1'b1, a, b, 5'd12);
    for (int k = 0; k < 200 && div_stall; k++) begin
      @(negedge clk);
      if (div_start) early_start = 1'b1;
    end
    checks++;
    if (early_start || div_stall) begin
      errors++;
      $display("[TB] FAIL timeout_hold: start_seen=%b stall=%b required 0/0", early_start, div_stall);
    end
    req0 = 1'b0;
    run_lone(0, a, b, 5'd12, fdiv_model(a, b), 1'b0, DIV_NOMINAL_LAT, "after_timeout");
    release_core(0);
  endtask
`endif

  task automatic test_reset_mid_op;
    logic [31:0] a, b;
    set_core(0, 1'b1, rand_fp(), rand_fp(), 5'd17);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    req0 = 1'b0;
    #1;
    checks++;
    if ({valid0, valid1, div_start, err, busy0, busy1} !== 6'b0) begin
      errors++;
      $display("[TB] FAIL midrst_ctrl: got %b required 000000", {valid0, valid1, div_start, err, busy0, busy1});
    end
    checks++;
    if ({result, tag_out, div_numA, div_numB} !== '0) begin
      errors++;
      $display("[TB] FAIL midrst_data: result=%h tag=%0d numA=%h numB=%h required all 0",
               result, tag_out, div_numA, div_numB);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ptr_model = 0;
    for (int k = 0; k < 20 && div_stall; k++) @(negedge clk);
    @(negedge clk);
    a = rand_fp();
    b = rand_fp();
    run_lone(1, a, b, 5'd2, fdiv_model(a, b), 1'b0, DIV_NOMINAL_LAT, "after_reset");
    release_core(1);
    // The grant above points priority back at core 0, as a fresh reset would
    test_simultaneous();
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_lone_and_special();
    test_random_lone();
    test_back_to_back();
`ifdef FP_DIV_ISSUE_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid_op();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
